// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad one column at a time,
// debounces presses and releases on a slow scan tick, and reports each
// accepted key once as a code on num with a single-cycle valid pulse.
module keypad_scanner #(
    parameter int CLK_DIV  = 50000,
    parameter int DEBOUNCE = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] num,
    output logic       valid,
    output logic       pressed
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE - 1);

    // State names carry a prefix so they cannot collide with the DEBOUNCE parameter.
    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    state_t           r_state;
    logic [3:0]       r_rowMeta;
    logic [3:0]       r_rowSync;
    logic [DIV_W-1:0] r_divCnt;
    logic [CNT_W-1:0] r_stableCnt;
    logic [1:0]       r_colIdx;
    logic [1:0]       r_rowIdx;
    logic [3:0]       r_col;
    logic [3:0]       r_num;
    logic             r_valid;
    logic             r_pressed;

    logic             w_tick;
    logic             w_anyLow;
    logic             w_keyLow;
    logic [1:0]       w_lowRow;
    logic [1:0]       w_colNext;
    logic [3:0]       w_colNextPattern;

    // Two-flop synchronizer for the asynchronous row lines; idles at "no key".
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rowMeta <= 4'hF;
            r_rowSync <= 4'hF;
        end else begin
            r_rowMeta <= row;
            r_rowSync <= r_rowMeta;
        end
    end

    // Dwell counter that sets the scan/sample rate; wraps after CLK_DIV cycles.
    always_ff @(posedge clk) begin
        if (reset || (r_divCnt == DIV_LAST)) begin
            r_divCnt <= '0;
        end else begin
            r_divCnt <= r_divCnt + 1'b1;
        end
    end

    assign w_tick    = (r_divCnt == DIV_LAST);
    assign w_anyLow  = ~(&r_rowSync);
    assign w_keyLow  = ~r_rowSync[r_rowIdx];
    assign w_colNext = r_colIdx + 2'd1;

    // Pick the lowest-index active row so simultaneous keys in a column resolve deterministically.
    always_comb begin
        w_lowRow = 2'd3;
        if (!r_rowSync[0]) begin
            w_lowRow = 2'd0;
        end else if (!r_rowSync[1]) begin
            w_lowRow = 2'd1;
        end else if (!r_rowSync[2]) begin
            w_lowRow = 2'd2;
        end
    end

    // Column drive pattern for the next column: only that column's line is pulled low.
    always_comb begin
        w_colNextPattern            = 4'hF;
        w_colNextPattern[w_colNext] = 1'b0;
    end

    // Scan/debounce FSM; all outputs are registered and only move on a tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_SCAN;
            r_colIdx    <= 2'd0;
            r_rowIdx    <= 2'd0;
            r_col       <= 4'b1110;
            r_num       <= 4'd0;
            r_valid     <= 1'b0;
            r_pressed   <= 1'b0;
            r_stableCnt <= '0;
        end else begin
            r_valid <= 1'b0;
            if (w_tick) begin
                case (r_state)
                    ST_SCAN: begin
                        if (w_anyLow) begin
                            r_rowIdx    <= w_lowRow;
                            r_stableCnt <= '0;
                            r_state     <= ST_DEBOUNCE;
                        end else begin
                            r_colIdx <= w_colNext;
                            r_col    <= w_colNextPattern;
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (w_keyLow) begin
                            r_stableCnt <= r_stableCnt + 1'b1;
                            if (r_stableCnt == DEB_LAST) begin
                                r_state   <= ST_PRESSED;
                                r_num     <= {r_rowIdx, r_colIdx};
                                r_valid   <= 1'b1;
                                r_pressed <= 1'b1;
                            end
                        end else begin
                            r_state  <= ST_SCAN;
                            r_colIdx <= w_colNext;
                            r_col    <= w_colNextPattern;
                        end
                    end
                    ST_PRESSED: begin
                        if (!w_keyLow) begin
                            r_stableCnt <= '0;
                            r_state     <= ST_RELEASE;
                        end
                    end
                    ST_RELEASE: begin
                        if (!w_keyLow) begin
                            if (r_stableCnt == DEB_LAST) begin
                                r_stableCnt <= '0;
                                r_state     <= ST_SCAN;
                                r_pressed   <= 1'b0;
                                r_colIdx    <= w_colNext;
                                r_col       <= w_colNextPattern;
                            end else begin
                                r_stableCnt <= r_stableCnt + 1'b1;
                            end
                        end else begin
                            r_stableCnt <= '0;
                        end
                    end
                    default: begin
                        r_state <= ST_SCAN;
                    end
                endcase
            end
        end
    end

    assign col     = r_col;
    assign num     = r_num;
    assign valid   = r_valid;
    assign pressed = r_pressed;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: drives a modelled 4x4 keypad (row lines follow the
// column drive and the set of held keys) and checks accepted key codes,
// pulse counts, latencies and reset behaviour against arithmetic expectations.
module tb_keypad_scanner;

    localparam int CLK_DIV = 4;
    localparam int DEB     = 3;
    localparam int LAT_MAX = (4 + DEB + 1) * CLK_DIV + 3;
    localparam int LAT_MIN = 3 + DEB * CLK_DIV;
    localparam int REL_MIN = 3 + DEB * CLK_DIV;
    localparam int REL_MAX = 2 + (DEB + 1) * CLK_DIV;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  num;
    logic        valid;
    logic        pressed;

    logic [15:0] keyDown = '0;
    logic        prevValid = 1'b0;
    int          checksTotal = 0;
    int          checksPassed = 0;
    int          validCount = 0;

    keypad_scanner #(.CLK_DIV(CLK_DIV), .DEBOUNCE(DEB)) dut (
        .clk(clk),
        .reset(reset),
        .row(row),
        .col(col),
        .num(num),
        .valid(valid),
        .pressed(pressed)
    );

    always #5 clk = ~clk;

    // Physical keypad: a row line is pulled low when a held key sits in a driven column.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keyDown[4*r+c] && !col[c]) row[r] = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checksTotal++;
        if (observed === expected) checksPassed++;
        else $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    endtask

    function automatic logic [3:0] colPattern(input int c);
        logic [3:0] p;
        p = 4'hF;
        p[c] = 1'b0;
        return p;
    endfunction

    // Continuous monitor: exactly one column driven, no back-to-back valid, count pulses.
    always @(negedge clk) begin
        checkOutput("col_onehot", $countones(~col), 1);
        checkOutput("valid_double", {31'd0, valid & prevValid}, 0);
        if (valid) validCount++;
        prevValid = valid;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic stepCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int key, input logic down);
        keyDown[key] = down;
    endtask

    task automatic waitValid(output int lat);
        lat = 0;
        while (valid !== 1'b1 && lat < LAT_MAX + 8) begin
            stepCycles(1);
            lat++;
        end
    endtask

    task automatic waitPressedLow(output int lat);
        lat = 0;
        while (pressed !== 1'b0 && lat < REL_MAX + 8) begin
            stepCycles(1);
            lat++;
        end
    endtask

    // Returns right after the edge on which the scan moved onto column c.
    task automatic waitForColumn(input int c, output logic found);
        logic [3:0] prevCol;
        found = 1'b0;
        for (int i = 0; i < 24 && !found; i++) begin
            prevCol = col;
            stepCycles(1);
            if (col != prevCol && col == colPattern(c)) found = 1'b1;
        end
    endtask

    task automatic pressAndRelease(input int key, input int hold);
        int start;
        int lat;
        start = validCount;
        applyStimulus(key, 1'b1);
        waitValid(lat);
        checkOutput("press_valid", {31'd0, valid}, 1);
        checkOutput("press_num", {28'd0, num}, key);
        checkOutput("press_pressed", {31'd0, pressed}, 1);
        checkOutput("press_latency", {31'd0, lat >= LAT_MIN && lat <= LAT_MAX}, 1);
        stepCycles(1);
        checkOutput("valid_width", {31'd0, valid}, 0);
        stepCycles(hold);
        checkOutput("single_pulse", validCount - start, 1);
        applyStimulus(key, 1'b0);
        waitPressedLow(lat);
        checkOutput("release_time", {31'd0, lat >= REL_MIN && lat <= REL_MAX}, 1);
        stepCycles(8);
        checkOutput("no_repeat_pulse", validCount - start, 1);
    endtask

    task automatic shortPress(input int r, input int c);
        int start;
        logic [3:0] prevNum;
        logic found;
        start = validCount;
        prevNum = num;
        waitForColumn(c, found);
        checkOutput("short_align", {31'd0, found}, 1);
        applyStimulus(4*r+c, 1'b1);
        stepCycles(8);
        checkOutput("short_no_pressed", {31'd0, pressed}, 0);
        applyStimulus(4*r+c, 1'b0);
        stepCycles(4);
        checkOutput("short_scan_resumes", {28'd0, col}, {28'd0, colPattern((c + 1) % 4)});
        stepCycles(12);
        checkOutput("short_no_valid", validCount - start, 0);
        checkOutput("short_num_kept", {28'd0, num}, {28'd0, prevNum});
    endtask

    task automatic multiPress(input int c, input logic [3:0] rowMask);
        int start;
        int lat;
        int low;
        int extra;
        start = validCount;
        low = -1;
        for (int r = 3; r >= 0; r--) begin
            if (rowMask[r]) begin
                applyStimulus(4*r+c, 1'b1);
                low = r;
            end
        end
        waitValid(lat);
        checkOutput("multi_valid", {31'd0, valid}, 1);
        checkOutput("multi_num", {28'd0, num}, 4*low + c);
        do extra = $urandom_range(0, 15); while (keyDown[extra]);
        applyStimulus(extra, 1'b1);
        stepCycles(30);
        checkOutput("multi_extra_ignored", validCount - start, 1);
        keyDown = '0;
        waitPressedLow(lat);
        checkOutput("multi_release", {31'd0, lat >= REL_MIN && lat <= REL_MAX}, 1);
        stepCycles(8);
        checkOutput("multi_single_pulse", validCount - start, 1);
    endtask

    initial begin
        int lat;
        int start;
        int key;
        int c;
        logic found;

        reset = 1'b1;
        stepCycles(3);
        checkOutput("reset_col", {28'd0, col}, 32'hE);
        checkOutput("reset_num", {28'd0, num}, 0);
        checkOutput("reset_valid", {31'd0, valid}, 0);
        checkOutput("reset_pressed", {31'd0, pressed}, 0);
        reset = 1'b0;

        // Idle scan: column advances once every CLK_DIV cycles and wraps.
        for (int k = 1; k <= 20; k++) begin
            stepCycles(1);
            checkOutput("idle_col", {28'd0, col}, {28'd0, colPattern((k / CLK_DIV) % 4)});
        end
        checkOutput("idle_no_valid", validCount, 0);

        // Row 2 on column 1 gives code 9.
        pressAndRelease(9, 40);
        for (int i = 0; i < 6; i++) begin
            pressAndRelease($urandom_range(0, 15), $urandom_range(20, 60));
        end

        // Brief contact shorter than the debounce window.
        shortPress(0, 3);
        shortPress($urandom_range(0, 3), $urandom_range(0, 3));

        // Several keys in one column: lowest row wins; later keys are ignored.
        multiPress(2, 4'b1010);
        for (int i = 0; i < 3; i++) begin
            multiPress($urandom_range(0, 3), 4'($urandom_range(1, 15)));
        end

        // Reset while PRESSED aborts, and the still-held key is accepted again.
        start = validCount;
        applyStimulus(13, 1'b1);
        waitValid(lat);
        checkOutput("rstp_num_before", {28'd0, num}, 13);
        stepCycles(10);
        reset = 1'b1;
        stepCycles(1);
        checkOutput("rstp_num", {28'd0, num}, 0);
        checkOutput("rstp_pressed", {31'd0, pressed}, 0);
        checkOutput("rstp_col", {28'd0, col}, 32'hE);
        checkOutput("rstp_valid", {31'd0, valid}, 0);
        reset = 1'b0;
        waitValid(lat);
        checkOutput("rstp_redetect_valid", {31'd0, valid}, 1);
        checkOutput("rstp_redetect_num", {28'd0, num}, 13);
        checkOutput("rstp_redetect_latency", {31'd0, lat <= LAT_MAX}, 1);
        applyStimulus(13, 1'b0);
        waitPressedLow(lat);
        stepCycles(8);
        checkOutput("rstp_pulses", validCount - start, 2);

        // Reset while DEBOUNCE: no pulse from the aborted attempt.
        c = $urandom_range(0, 3);
        key = 4 * $urandom_range(0, 3) + c;
        start = validCount;
        waitForColumn(c, found);
        checkOutput("rstd_align", {31'd0, found}, 1);
        applyStimulus(key, 1'b1);
        stepCycles(6);
        reset = 1'b1;
        stepCycles(1);
        reset = 1'b0;
        checkOutput("rstd_num", {28'd0, num}, 0);
        stepCycles(14);
        checkOutput("rstd_no_pulse", validCount - start, 0);
        waitValid(lat);
        checkOutput("rstd_redetect_num", {28'd0, num}, key);
        applyStimulus(key, 1'b0);
        waitPressedLow(lat);
        stepCycles(8);
        checkOutput("rstd_pulses", validCount - start, 1);

        // Release bounce: two low samples inside RELEASE restart the release count.
        key = $urandom_range(0, 15);
        start = validCount;
        applyStimulus(key, 1'b1);
        waitValid(lat);
        checkOutput("bounce_num", {28'd0, num}, key);
        stepCycles(8);
        applyStimulus(key, 1'b0);
        stepCycles(4);
        applyStimulus(key, 1'b1);
        stepCycles(8);
        applyStimulus(key, 1'b0);
        stepCycles(11);
        checkOutput("bounce_pressed_held", {31'd0, pressed}, 1);
        stepCycles(1);
        checkOutput("bounce_pressed_fall", {31'd0, pressed}, 0);
        stepCycles(8);
        checkOutput("bounce_single_pulse", validCount - start, 1);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
